data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 tb/tb_data_mem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle word data memory slave: req/ready handshake, LATENCY wait states, error reporting.
// Optional access counters (rd_cnt_o / wr_cnt_o) are enabled by defining DMEM_ACCESS_CNT_EN.
module data_mem_responder #(
   parameter int DEPTH   = 128,
   parameter int LATENCY = 2,
   parameter int ADDR_W  = 7
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        busy_o
`ifdef DMEM_ACCESS_CNT_EN
   ,
   output logic [31:0] rd_cnt_o,
   output logic [31:0] wr_cnt_o
`endif
);

   // state | meaning
   // IDLE  | waiting for req_i; request fields latched on acceptance
   // WAIT  | wait states, counter runs down to 1
   // DONE  | one-cycle ready_o pulse; storage/rdata updated on entry
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic              err_q;
   logic [31:0]       rdata_q;
   logic [31:0]       mem_q [DEPTH];

   logic              cur_we;
   logic [31:0]       cur_addr;
   logic [31:0]       cur_wdata;
   logic [ADDR_W-1:0] idx;
   logic              access_err;
   logic              enter_done;
   logic              accept;

   // With LATENCY=1 DONE is entered on the acceptance edge, so the live inputs
   // must be used there instead of the not-yet-latched copy.
   assign cur_we     = (state_q == S_IDLE) ? we_i    : we_q;
   assign cur_addr   = (state_q == S_IDLE) ? addr_i  : addr_q;
   assign cur_wdata  = (state_q == S_IDLE) ? wdata_i : wdata_q;
   assign idx        = cur_addr[ADDR_W+1:2];
   assign access_err = (|cur_addr[1:0]) || (|cur_addr[31:ADDR_W+2]) ||
                       ({1'b0, idx} >= (ADDR_W+1)'(DEPTH));
   assign accept     = (state_q == S_IDLE) && req_i;
   assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               if (LATENCY > 1) begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(LATENCY - 1);
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready_o = (state_q == S_DONE);
      busy_o  = (state_q != S_IDLE);
      err_o   = (state_q == S_DONE) && err_q;
   end

   assign rdata_o = rdata_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
         end
         if (enter_done) begin
            err_q   <= access_err;
            rdata_q <= access_err ? 32'h0 : mem_q[idx];
         end
      end
   end

   // Storage is deliberately not reset; rst_i only blocks a commit during reset.
   always_ff @(posedge clk_i) begin
      if (rst_i && enter_done && cur_we && !access_err) mem_q[idx] <= cur_wdata;
   end

`ifdef DMEM_ACCESS_CNT_EN
   logic [31:0] rd_cnt_q, wr_cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else if (enter_done && !access_err) begin
         if (cur_we) wr_cnt_q <= wr_cnt_q + 32'd1;
         else        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
   end

   assign rd_cnt_o = rd_cnt_q;
   assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=2 main instance, LATENCY=1 back-to-back instance).
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, req1;
   logic        we;
   logic [31:0] addr, wdata;
   logic        ready, err, busy;
   logic [31:0] rdata;
   logic        ready1, err1, busy1;
   logic [31:0] rdata1;
`ifdef DMEM_ACCESS_CNT_EN
   logic [31:0] rd_cnt, wr_cnt, rd_cnt1, wr_cnt1;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(128), .LATENCY(2), .ADDR_W(7)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .ready_o(ready), .rdata_o(rdata), .err_o(err), .busy_o(busy)
`ifdef DMEM_ACCESS_CNT_EN
      , .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
`endif
   );

   data_mem_responder #(.DEPTH(128), .LATENCY(1), .ADDR_W(7)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .ready_o(ready1), .rdata_o(rdata1), .err_o(err1), .busy_o(busy1)
`ifdef DMEM_ACCESS_CNT_EN
      , .rd_cnt_o(rd_cnt1), .wr_cnt_o(wr_cnt1)
`endif
   );

   // Issues one request on u_dut starting from IDLE; lat = edges from request to ready seen (-1 on timeout).
   task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic rdy_after);
      we = w; addr = a; wdata = d; req = 1'b1;
      lat = -1; rd = '0; er = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (ready) begin
            lat = k; rd = rdata; er = err;
            break;
         end
      end
      req = 1'b0;
      @(posedge clk); #1;
      rdy_after = ready;
   endtask

   task automatic test_reset();
      int k;
      rst = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h10; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ready !== 1'b0)   begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
      checks++; if (err !== 1'b0)     begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (rdata !== 32'h0)  begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL reset_release_accept busy=%b exp=1", busy); end
      k = 0;
      while (!ready && k < 20) begin @(posedge clk); #1; k++; end
      checks++; if (ready !== 1'b1)   begin failures++; $display("FAIL reset_release_done ready=%b exp=1", ready); end
      req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      int lat; logic [31:0] rd; logic er, ra;
      run_txn(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er, ra);
      checks++; if (lat !== 2)   begin failures++; $display("FAIL wr_latency got=%0d exp=2", lat); end
      checks++; if (er !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", er); end
      checks++; if (ra !== 1'b0) begin failures++; $display("FAIL wr_pulse_width ready_after=%b exp=0", ra); end
      run_txn(1'b0, 32'h10, 32'h0, lat, rd, er, ra);
      checks++; if (lat !== 2)           begin failures++; $display("FAIL rd_latency got=%0d exp=2", lat); end
      checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
      checks++; if (er !== 1'b0)         begin failures++; $display("FAIL rd_err got=%b exp=0", er); end
      checks++; if (ra !== 1'b0)         begin failures++; $display("FAIL rd_pulse_width ready_after=%b exp=0", ra); end
      checks++; if (err !== 1'b0)        begin failures++; $display("FAIL err_outside_ready got=%b exp=0", err); end
   endtask

   task automatic test_back_to_back();
      logic exp_v;
      we = 1'b0; addr = 32'h10; req1 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         exp_v = (k % 2) == 1;
         checks++; if (ready1 !== exp_v) begin failures++; $display("FAIL b2b_ready edge=%0d got=%b exp=%b", k, ready1, exp_v); end
         checks++; if (busy1 !== exp_v)  begin failures++; $display("FAIL b2b_busy edge=%0d got=%b exp=%b", k, busy1, exp_v); end
      end
      req1 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_errors();
      int lat; logic [31:0] rd; logic er, ra;
      run_txn(1'b1, 32'h13, 32'h12345678, lat, rd, er, ra);
      checks++; if (lat !== 2)      begin failures++; $display("FAIL mis_latency got=%0d exp=2", lat); end
      checks++; if (er !== 1'b1)    begin failures++; $display("FAIL mis_err got=%b exp=1", er); end
      checks++; if (rd !== 32'h0)   begin failures++; $display("FAIL mis_rdata got=%h exp=0", rd); end
      run_txn(1'b1, 32'h200, 32'h12345678, lat, rd, er, ra);
      checks++; if (er !== 1'b1)    begin failures++; $display("FAIL oor_err got=%b exp=1", er); end
      checks++; if (rd !== 32'h0)   begin failures++; $display("FAIL oor_rdata got=%h exp=0", rd); end
      run_txn(1'b0, 32'h10, 32'h0, lat, rd, er, ra);
      checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL err_keep_data got=%h exp=deadbeef", rd); end
      checks++; if (er !== 1'b0)    begin failures++; $display("FAIL err_keep_err got=%b exp=0", er); end
      run_txn(1'b0, 32'h2, 32'h0, lat, rd, er, ra);
      checks++; if (er !== 1'b1)    begin failures++; $display("FAIL mis_rd_err got=%b exp=1", er); end
      checks++; if (rd !== 32'h0)   begin failures++; $display("FAIL mis_rd_rdata got=%h exp=0", rd); end
   endtask

   task automatic test_boundary();
      int lat; logic [31:0] rd; logic er, ra;
      run_txn(1'b1, 32'h1FC, 32'h0BADCAFE, lat, rd, er, ra);
      checks++; if (er !== 1'b0)         begin failures++; $display("FAIL last_wr_err got=%b exp=0", er); end
      run_txn(1'b0, 32'h1FC, 32'h0, lat, rd, er, ra);
      checks++; if (rd !== 32'h0BADCAFE) begin failures++; $display("FAIL last_rd_data got=%h exp=0badcafe", rd); end
      checks++; if (er !== 1'b0)         begin failures++; $display("FAIL last_rd_err got=%b exp=0", er); end
   endtask

   task automatic test_latched_fields();
      int lat; logic [31:0] rd; logic er, ra;
      int k;
      we = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; req = 1'b1;
      @(posedge clk); #1;
      we = 1'b0; addr = 32'h34; wdata = 32'h0; req = 1'b0;
      k = 0;
      while (!ready && k < 20) begin @(posedge clk); #1; k++; end
      checks++; if (k !== 1)      begin failures++; $display("FAIL latch_done_edges got=%0d exp=1", k); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL latch_err got=%b exp=0", err); end
      @(posedge clk); #1;
      run_txn(1'b0, 32'h30, 32'h0, lat, rd, er, ra);
      checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL latch_data got=%h exp=cafef00d", rd); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; logic er, ra;
      run_txn(1'b1, 32'h20, 32'h11111111, lat, rd, er, ra);
      we = 1'b1; addr = 32'h20; wdata = 32'hA5A5A5A5; req = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1)  begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
      rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL mid_busy_reset got=%b exp=0", busy); end
      req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         checks++; if (ready !== 1'b0) begin failures++; $display("FAIL mid_no_ready cyc=%0d got=%b exp=0", k, ready); end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL mid_no_ready_after got=%b exp=0", ready); end
      run_txn(1'b0, 32'h20, 32'h0, lat, rd, er, ra);
      checks++; if (rd !== 32'h11111111) begin failures++; $display("FAIL mid_old_data got=%h exp=11111111", rd); end
   endtask

`ifdef DMEM_ACCESS_CNT_EN
   task automatic test_counters();
      int lat; logic [31:0] rd; logic er, ra;
      rst = 1'b0; @(posedge clk); #1; rst = 1'b1;
      checks++; if (rd_cnt !== 32'd0) begin failures++; $display("FAIL cnt_rd_init got=%0d exp=0", rd_cnt); end
      checks++; if (wr_cnt !== 32'd0) begin failures++; $display("FAIL cnt_wr_init got=%0d exp=0", wr_cnt); end
      run_txn(1'b0, 32'h10,  32'h0, lat, rd, er, ra);
      run_txn(1'b0, 32'h20,  32'h0, lat, rd, er, ra);
      run_txn(1'b1, 32'h40,  32'h1, lat, rd, er, ra);
      run_txn(1'b0, 32'h1FC, 32'h0, lat, rd, er, ra);
      run_txn(1'b1, 32'h44,  32'h2, lat, rd, er, ra);
      run_txn(1'b0, 32'h42,  32'h0, lat, rd, er, ra);
      checks++; if (rd_cnt !== 32'd3) begin failures++; $display("FAIL cnt_rd got=%0d exp=3", rd_cnt); end
      checks++; if (wr_cnt !== 32'd2) begin failures++; $display("FAIL cnt_wr got=%0d exp=2", wr_cnt); end
      rst = 1'b0; #1;
      checks++; if (rd_cnt !== 32'd0) begin failures++; $display("FAIL cnt_rd_reset got=%0d exp=0", rd_cnt); end
      checks++; if (wr_cnt !== 32'd0) begin failures++; $display("FAIL cnt_wr_reset got=%0d exp=0", wr_cnt); end
      @(posedge clk); #1; rst = 1'b1;
   endtask
`endif

   initial begin
      rst = 1'b0; req = 1'b0; req1 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_errors();
      test_boundary();
      test_latched_fields();
      test_reset_mid();
`ifdef DMEM_ACCESS_CNT_EN
      test_counters();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
